decoded_instr_buffer: RTL and testbench

- Elastic FIFO sitting directly downstream of the decoder's reduction-OR stage.
- Captures each merged decoded_instr_t word and holds it until the issue/dispatch stage accepts it.
- Uses valid/ready handshakes on both sides, so decoder timing is decoupled from back-end stalls.
- Supports a pipeline flush for branch mispredict or exception redirect.

---
 rtl/decoded_instr_buffer.sv | 108 ++++++++++
 tb/tb_decoded_instr_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoded_instr_buffer.sv
// decoded_instr_buffer: elastic FIFO between the decoder reduction-OR stage and
// issue/dispatch. It holds merged decoded_instr_t words under valid/ready
// handshakes on both sides and supports a synchronous pipeline flush.
// Optional feature macro: DECODED_INSTR_BUFFER_BYPASS_EN. When it is defined,
// an empty buffer forwards instr_i to instr_o in the same cycle.

package decoded_instr_buffer_pkg;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] imm;
  } decoded_instr_t;
endpackage

module decoded_instr_buffer
  import decoded_instr_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             flush_i,
  input  decoded_instr_t   instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  output decoded_instr_t   instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  decoded_instr_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic empty;
  logic full;
  logic push;
  logic push_mem;
  logic pop_mem;

  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign count_o       = count_q;
  // Ready depends only on stored occupancy, so a pop while full cannot admit a push.
  assign instr_ready_o = !full;
  assign push          = instr_valid_i & instr_ready_o;

`ifdef DECODED_INSTR_BUFFER_BYPASS_EN
  logic bypass_hit;

  // An empty buffer presents the incoming word directly; if it is taken in the
  // same cycle it never enters storage.
  assign bypass_hit    = empty & instr_valid_i;
  assign instr_valid_o = !empty | (bypass_hit & !flush_i);
  assign instr_o       = empty ? instr_i : mem_q[rd_ptr_q];
  assign pop_mem       = !empty & instr_ready_i;
  assign push_mem      = push & !(bypass_hit & instr_ready_i);
`else
  assign instr_valid_o = !empty;
  assign instr_o       = mem_q[rd_ptr_q];
  assign pop_mem       = instr_valid_o & instr_ready_i;
  assign push_mem      = push;
`endif

  // Pointer and occupancy tracking; flush discards everything including a same-cycle push.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_mem) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_mem)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_mem, pop_mem})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_mem && !flush_i) mem_q[wr_ptr_q] <= instr_i;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (arst_i)
    count_q <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (arst_i)
    !(push_mem && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (arst_i)
    !(pop_mem && empty));
  a_producer_hold: assert property (@(posedge clk_i) disable iff (arst_i)
    (instr_valid_i && !instr_ready_o && !flush_i) |=> $stable(instr_i));

endmodule

// File: tb/tb_decoded_instr_buffer.sv
// Scoreboard bench for decoded_instr_buffer: directed scenarios followed by
// randomized traffic, checked against a queue-level reference model.
module tb_decoded_instr_buffer;
  import decoded_instr_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             arst_i;
  logic             flush_i;
  decoded_instr_t   instr_i;
  logic             instr_valid_i;
  logic             instr_ready_o;
  decoded_instr_t   instr_o;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic [CNT_W-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;
  decoded_instr_t exp_q [$];

  decoded_instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .flush_i       (flush_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one word and wait until it is taken at an edge.
  task automatic send(input logic [31:0] d);
    int g;
    instr_valid_i = 1'b1;
    instr_i       = decoded_instr_t'(d);
    g = 0;
    while (!instr_ready_o && g < 50) begin
      step();
      g++;
    end
    check("send_accept", 64'(g < 50), 64'd1);
    step();
    instr_valid_i = 1'b0;
  endtask

  // Monitor and reference model: compare the visible outputs with the expected
  // queue, then apply the FIFO rules for the upcoming edge.
  always @(negedge clk_i) begin : monitor
    int   n;
    logic exp_valid;
    logic do_push;
    logic do_pop;
    decoded_instr_t exp_word;
    if (arst_i) begin
      exp_q.delete();
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_valid", 64'(instr_valid_o), 64'd0);
      check("rst_ready", 64'(instr_ready_o), 64'd1);
    end else begin
      n = exp_q.size();
`ifdef DECODED_INSTR_BUFFER_BYPASS_EN
      exp_valid = (n != 0) || (instr_valid_i && !flush_i);
`else
      exp_valid = (n != 0);
`endif
      check("count", 64'(count_o), 64'(n));
      check("ready", 64'(instr_ready_o), 64'(n != DEPTH));
      check("valid", 64'(instr_valid_o), 64'(exp_valid));
      if (exp_valid && instr_ready_i) begin
        exp_word = (n != 0) ? exp_q[0] : instr_i;
        check("data", 64'(instr_o), 64'(exp_word));
      end
      if (flush_i) begin
        exp_q.delete();
      end else begin
        do_push = instr_valid_i && (n != DEPTH);
        do_pop  = exp_valid && instr_ready_i;
        if (do_pop && n != 0) void'(exp_q.pop_front());
        if (do_push && !(do_pop && n == 0)) exp_q.push_back(instr_i);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic hold;
    arst_i        = 1'b1;
    flush_i       = 1'b0;
    instr_i       = '0;
    instr_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 arst_i = 1'b0;
    step();
    check("post_rst_count", 64'(count_o), 64'd0);

    // Single push with an always-ready consumer.
    instr_ready_i = 1'b1;
    instr_valid_i = 1'b1;
    instr_i       = decoded_instr_t'(32'hA5A5_A5A5);
`ifdef DECODED_INSTR_BUFFER_BYPASS_EN
    check("bypass_valid", 64'(instr_valid_o), 64'd1);
`endif
    step();
    instr_valid_i = 1'b0;
`ifdef DECODED_INSTR_BUFFER_BYPASS_EN
    check("single_count", 64'(count_o), 64'd0);
`else
    check("single_count", 64'(count_o), 64'd1);
`endif
    step();
    check("single_drain", 64'(count_o), 64'd0);

    // Fill to full, hold tag 5, then drain in order.
    instr_ready_i = 1'b0;
    for (int t = 1; t <= 4; t++) send(32'(t));
    instr_valid_i = 1'b1;
    instr_i       = decoded_instr_t'(32'd5);
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(instr_ready_o), 64'd0);
    step();
    step();
    instr_ready_i = 1'b1;
    step();
    check("full_pop_only", 64'(count_o), 64'd3);
    check("full_ready_back", 64'(instr_ready_o), 64'd1);
    step();
    instr_valid_i = 1'b0;
    repeat (6) step();

    // Streaming at occupancy 2 with simultaneous push and pop.
    instr_ready_i = 1'b0;
    send(32'd10);
    send(32'd11);
    instr_ready_i = 1'b1;
    for (int t = 12; t < 22; t++) begin
      instr_valid_i = 1'b1;
      instr_i       = decoded_instr_t'(32'(t));
      step();
      check("stream_count", 64'(count_o), 64'd2);
    end
    instr_valid_i = 1'b0;
    repeat (4) step();

    // Flush at occupancy 3 with a same-cycle push of tag 9.
    instr_ready_i = 1'b0;
    send(32'd20);
    send(32'd21);
    send(32'd22);
    instr_valid_i = 1'b1;
    instr_i       = decoded_instr_t'(32'd9);
    flush_i       = 1'b1;
    step();
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(instr_valid_o), 64'd0);
    check("flush_ready", 64'(instr_ready_o), 64'd1);
    instr_ready_i = 1'b1;
    repeat (3) step();

    // Asynchronous reset in the middle of a cycle at occupancy 2.
    instr_ready_i = 1'b0;
    send(32'd30);
    send(32'd31);
    #2 arst_i = 1'b1;
    #1;
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_valid", 64'(instr_valid_o), 64'd0);
    check("arst_ready", 64'(instr_ready_o), 64'd1);
    step();
    step();
    #2 arst_i = 1'b0;
    step();

    // Randomized traffic with alternating consumer pressure and rare flushes.
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        instr_valid_i = ($urandom_range(0, 2) != 0);
        instr_i       = decoded_instr_t'($urandom);
      end
      if (((c / 100) % 2) == 1) instr_ready_i = ($urandom_range(0, 3) == 0);
      else                      instr_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 31) == 0);
      hold    = instr_valid_i && !instr_ready_o && !flush_i;
      step();
    end
    flush_i       = 1'b0;
    instr_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    repeat (8) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(count_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
